// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM states, PC step and instruction-type field decode.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   localparam int unsigned PC_STEP   = 4;
   localparam int unsigned ITYPE_LSB = 0;
   localparam int unsigned ITYPE_MSB = 1;

   typedef enum logic [1:0] {
      ITYPE_ALU = 2'b00,
      ITYPE_MEM = 2'b01,
      ITYPE_SFU = 2'b10
   } itype_t;

   function automatic itype_t instr_type(input logic [31:0] instr);
      return itype_t'(instr[ITYPE_MSB:ITYPE_LSB]);
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small circular FIFO holding returned instruction words; clear wins over push/pop.
module fetch_buffer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CW = $clog2(DEPTH + 1),
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   input  logic             clear_i,
   output logic [CW-1:0]    count_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    count;
   logic             do_pop;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign do_pop  = pop_i && (count != '0);
   assign count_o = count;
   assign empty_o = (count == '0);
   assign head_o  = mem[rd_ptr];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear_i) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_i) begin
            mem[wr_ptr] <= data_i;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         count <= count + CW'(push_i) - CW'(do_pop);
      end
   end

   // The issuing side's credit rule guarantees a free slot for every response.
   a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(push_i && !do_pop && !clear_i && (count == CW'(DEPTH))));

endmodule

// File: rtl/fragment_fetch_unit.sv
// Shader instruction fetch: PC, credit-limited memory reads, response buffer and flush handling.
module fragment_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned MAX_OUT = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [ADDR_W-1:0] entry_pc_i,
   input  logic              halt_i,
   output logic              busy_o,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] redirect_pc_i,
   output logic [WIDTH-1:0]  instr_o,
   output logic              valid_o,
   input  logic              stall_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_gnt_i,
   input  logic              imem_rvalid_i,
   input  logic [WIDTH-1:0]  imem_rdata_i
);

   localparam int unsigned CW = $clog2(MAX_OUT + 1);

   fetch_state_t      state;
   logic [ADDR_W-1:0] pc;
   logic [CW-1:0]     out_cnt;
   logic [CW-1:0]     drop_cnt;
   logic [CW-1:0]     buf_count;
   logic [CW-1:0]     out_next;
   logic [CW:0]       inflight;
   logic              buf_empty;
   logic              flush_act;
   logic              gnt;
   logic              rsp;
   logic              push;
   logic              pop;

   // Credits cover both in-flight reads and buffered words, so the buffer never overflows.
   assign inflight    = {1'b0, out_cnt} + {1'b0, buf_count};
   assign imem_req_o  = (state == RUN) && (inflight < (CW+1)'(MAX_OUT));
   assign imem_addr_o = pc;
   assign busy_o      = (state != IDLE);

   assign flush_act = flush_i && (state != IDLE);
   assign gnt       = imem_req_o && imem_gnt_i;
   assign rsp       = imem_rvalid_i && (out_cnt != '0);
   assign push      = rsp && (drop_cnt == '0) && !flush_act;
   assign valid_o   = !buf_empty && !flush_act;
   assign pop       = valid_o && !stall_i;
   assign out_next  = out_cnt + CW'(gnt) - CW'(rsp);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= IDLE;
         pc       <= '0;
         out_cnt  <= '0;
         drop_cnt <= '0;
      end else begin
         out_cnt <= out_next;
         // Everything still in flight after a flush belongs to the old stream.
         if (flush_act) begin
            drop_cnt <= out_next;
         end else if (rsp && (drop_cnt != '0)) begin
            drop_cnt <= drop_cnt - CW'(1);
         end

         unique case (state)
            IDLE: begin
               if (start_i) begin
                  pc    <= entry_pc_i;
                  state <= RUN;
               end
            end
            RUN: begin
               if (flush_i) begin
                  pc <= redirect_pc_i;
               end else begin
                  if (gnt) begin
                     pc <= pc + ADDR_W'(PC_STEP);
                  end
                  if (halt_i) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (flush_i) begin
                  pc <= redirect_pc_i;
               end else if ((out_cnt == '0) && (drop_cnt == '0) && buf_empty) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   fetch_buffer #(
      .WIDTH (WIDTH),
      .DEPTH (MAX_OUT)
   ) u_buf (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  (imem_rdata_i),
      .pop_i   (pop),
      .clear_i (flush_act),
      .count_o (buf_count),
      .empty_o (buf_empty),
      .head_o  (instr_o)
   );

endmodule

// File: tb/tb_fragment_fetch_unit.sv
// Scoreboard bench: randomized memory/stall/flush traffic against a stream-level fetch model.
module tb_fragment_fetch_unit;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        start_i;
   logic [31:0] entry_pc_i;
   logic        halt_i;
   logic        busy_o;
   logic        flush_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] instr_o;
   logic        valid_o;
   logic        stall_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;

   fragment_fetch_unit #(.WIDTH(32), .ADDR_W(32), .MAX_OUT(2)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .start_i       (start_i),
      .entry_pc_i    (entry_pc_i),
      .halt_i        (halt_i),
      .busy_o        (busy_o),
      .flush_i       (flush_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_o       (instr_o),
      .valid_o       (valid_o),
      .stall_i       (stall_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { logic [31:0] data; int unsigned epoch; } exp_t;
   typedef struct { logic [31:0] data; int unsigned due; } rsp_t;

   exp_t        exp_q[$];
   rsp_t        mem_q[$];
   int unsigned epoch = 0;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] model_pc = '0;
   bit          zero_wait = 1'b0;
   bit          gnt_always = 1'b0;
   int unsigned lat_lo = 1;
   int unsigned lat_hi = 1;
   bit          chk_first = 1'b0;
   logic [31:0] chk_first_addr = '0;

   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic int live_count();
      int c = 0;
      foreach (exp_q[i]) if (exp_q[i].epoch == epoch) c++;
      return c;
   endfunction

   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_true(input string name, input bit ok, input longint act, input longint req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d required %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #2;
   endtask

   // Memory: in-order responses, grant/latency randomised unless zero-wait.
   initial begin
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
      forever begin
         @(posedge clk_i);
         #1;
         imem_gnt_i = (zero_wait || gnt_always) ? 1'b1 : ($urandom_range(0, 3) != 0);
         if (mem_q.size() > 0 && mem_q[0].due <= cyc && (zero_wait || $urandom_range(0, 3) != 0)) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_q[0].data;
            void'(mem_q.pop_front());
         end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
         end
      end
   end

   // Monitor: a granted word is delivered iff no flush/reset hits between its grant and its transfer.
   initial begin
      bit          in_rst = 1'b0;
      bit          p_req = 1'b0, p_gnt = 1'b0, p_flush = 1'b0, p_halt = 1'b0;
      bit          p_valid = 1'b0, p_stall = 1'b0;
      logic [31:0] p_addr = '0, p_instr = '0;
      bit          flush_act;
      exp_t        e;
      int unsigned lat;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            if (!in_rst) begin
               epoch++;
               exp_q.delete();
            end
            in_rst  = 1'b1;
            p_req   = 1'b0;
            p_valid = 1'b0;
         end else begin
            in_rst    = 1'b0;
            flush_act = busy_o && flush_i;
            if (p_req && !p_gnt && !p_flush && !p_halt) begin
               check_eq("req_hold", imem_req_o, 1);
               check_eq("addr_hold", imem_addr_o, p_addr);
            end
            if (p_valid && p_stall) begin
               check_eq("valid_hold", valid_o || flush_act, 1);
               check_eq("instr_hold", instr_o, p_instr);
            end
            if (flush_act) check_eq("valid_in_flush", valid_o, 0);
            if (valid_o && !stall_i) begin
               while (exp_q.size() > 0 && exp_q[0].epoch != epoch) void'(exp_q.pop_front());
               check_true("xfer_expected", exp_q.size() != 0, instr_o, 0);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check_eq("instr", instr_o, e.data);
                  if (chk_first) begin
                     check_eq("first_after_flush", instr_o, memf(chk_first_addr));
                     chk_first = 1'b0;
                  end
               end
            end
            if (imem_req_o && imem_gnt_i) begin
               check_eq("req_addr", imem_addr_o, model_pc);
               exp_q.push_back('{data: memf(model_pc), epoch: epoch});
               lat = zero_wait ? 1 : $urandom_range(lat_lo, lat_hi);
               mem_q.push_back('{data: memf(imem_addr_o), due: cyc + lat});
               model_pc = model_pc + 32'd4;
            end
            if (flush_act) begin
               epoch++;
               model_pc = redirect_pc_i;
            end else if (!busy_o && start_i) begin
               model_pc = entry_pc_i;
            end
            p_req   = imem_req_o;
            p_gnt   = imem_req_o && imem_gnt_i;
            p_flush = flush_act;
            p_halt  = halt_i;
            p_addr  = imem_addr_o;
            p_valid = valid_o;
            p_stall = stall_i;
            p_instr = instr_o;
         end
      end
   end

   task automatic check_reset_outs(input string tag);
      check_eq({tag, "_req"}, imem_req_o, 0);
      check_eq({tag, "_valid"}, valid_o, 0);
      check_eq({tag, "_busy"}, busy_o, 0);
      check_eq({tag, "_instr"}, instr_o, 0);
      check_eq({tag, "_addr"}, imem_addr_o, 0);
   endtask

   task automatic wait_outstanding(input int want, input string name);
      int n = 0;
      while (mem_q.size() != want && n < 60) begin
         step();
         n++;
      end
      check_true(name, mem_q.size() == want, mem_q.size(), want);
   endtask

   initial begin
      int xfers, hits, n, seen;
      rst_ni = 1'b0; start_i = 1'b0; halt_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
      entry_pc_i = '0; redirect_pc_i = '0;
      step(); step();
      check_reset_outs("reset");
      rst_ni = 1'b1;
      step();

      // zero-wait streaming from 0x100
      zero_wait = 1'b1;
      entry_pc_i = 32'h100; start_i = 1'b1;
      step();
      start_i = 1'b0;
      check_eq("start_busy", busy_o, 1);
      check_eq("start_req", imem_req_o, 1);
      check_eq("start_addr", imem_addr_o, 32'h100);
      repeat (12) step();
      xfers = 0;
      repeat (10) begin
         if (valid_o && !stall_i) xfers++;
         step();
      end
      check_true("throughput", xfers >= 6, xfers, 6);

      // stall with a full buffer
      stall_i = 1'b1;
      repeat (4) step();
      repeat (5) begin
         check_eq("stall_no_req", imem_req_o, 0);
         check_eq("stall_valid", valid_o, 1);
         step();
      end
      stall_i = 1'b0;
      repeat (8) step();

      // flush with two reads outstanding
      zero_wait = 1'b0; gnt_always = 1'b1; lat_lo = 4; lat_hi = 4;
      wait_outstanding(2, "wait_two_out");
      flush_i = 1'b1; redirect_pc_i = 32'h400;
      chk_first_addr = 32'h400; chk_first = 1'b1;
      step();
      flush_i = 1'b0;
      repeat (25) step();
      check_true("first_seen", !chk_first, chk_first, 0);

      // flush coincident with rvalid and a grant
      gnt_always = 1'b0; lat_lo = 1; lat_hi = 2;
      hits = 0; n = 0;
      while (hits < 3 && n < 400) begin
         if (imem_rvalid_i && imem_req_o && imem_gnt_i) begin
            flush_i = 1'b1;
            redirect_pc_i = 32'($urandom_range(0, 1023)) << 2;
            hits++;
         end
         step();
         flush_i = 1'b0;
         n++;
      end
      check_true("coincident_hits", hits == 3, hits, 3);
      repeat (20) step();

      // random traffic, including PC wrap
      lat_lo = 1; lat_hi = 3;
      repeat (600) begin
         stall_i = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 19) == 0) begin
            flush_i = 1'b1;
            redirect_pc_i = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : 32'($urandom_range(0, 4095)) << 2;
         end
         step();
         flush_i = 1'b0;
      end
      stall_i = 1'b0;

      // halt with one read outstanding
      wait_outstanding(1, "wait_one_out");
      halt_i = 1'b1;
      step();
      halt_i = 1'b0;
      n = 0;
      while (busy_o && n < 60) begin
         check_eq("drain_no_req", imem_req_o, 0);
         step();
         n++;
      end
      check_true("busy_fell", !busy_o, n, 60);
      check_eq("drain_delivered", live_count(), 0);
      check_eq("drain_mem_empty", mem_q.size(), 0);

      // reset mid-stream with two reads outstanding
      gnt_always = 1'b1; lat_lo = 6; lat_hi = 6;
      entry_pc_i = 32'h200; start_i = 1'b1;
      step();
      start_i = 1'b0;
      wait_outstanding(2, "wait_rst_out");
      #1 rst_ni = 1'b0;
      #1 check_reset_outs("async_rst");
      @(posedge clk_i);
      @(posedge clk_i);
      #2 rst_ni = 1'b1;
      seen = 0;
      repeat (12) begin
         step();
         if (imem_rvalid_i) seen++;
         check_eq("post_rst_valid", valid_o, 0);
         check_eq("post_rst_busy", busy_o, 0);
      end
      check_true("late_rvalid_seen", seen > 0, seen, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
